// File: rtl/char_rotator_if.sv
// rtl/char_rotator_if.sv - control/display bundle between a driver and char_rotator.
interface char_rotator_if #(
   parameter int NUM_DISP = 6,
   parameter int MSG_LEN  = 8
);
   localparam int OFF_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

   logic                    run;
   logic                    dir;
   logic                    step;
   logic                    msg_load;
   logic [3*MSG_LEN-1:0]    msg_data;
   logic [3*NUM_DISP-1:0]   codes;
   logic [OFF_W-1:0]        offset;
   logic                    tick;

   modport master (
      output run, dir, step, msg_load, msg_data,
      input  codes, offset, tick
   );

   modport slave (
      input  run, dir, step, msg_load, msg_data,
      output codes, offset, tick
   );
endinterface

// File: rtl/char_rotator.sv
// rtl/char_rotator.sv - scrolling window over a message buffer of 3-bit character codes.
module char_rotator #(
   parameter int                   NUM_DISP    = 6,
   parameter int                   MSG_LEN     = 8,
   parameter int                   TICK_DIV    = 50000000,
   parameter logic [3*MSG_LEN-1:0] DEFAULT_MSG = '0
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   char_rotator_if.slave bus
);
   localparam int OFF_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int DIV_W = $clog2(TICK_DIV);
   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(MSG_LEN - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [3*MSG_LEN-1:0]  msg_buf;
   logic [OFF_W-1:0]      off_q;
   logic [OFF_W-1:0]      next_off;
   logic [DIV_W-1:0]      div_cnt;
   logic                  step_q;
   logic                  tick_q;
   logic [3*NUM_DISP-1:0] codes_q;
   logic                  auto_req;
   logic                  step_req;

   // start + i never exceeds 2*MSG_LEN-2, so one conditional subtract is the modulo
   function automatic logic [3*NUM_DISP-1:0] window(
      input logic [3*MSG_LEN-1:0] msg,
      input logic [OFF_W-1:0]     start
   );
      logic [3*NUM_DISP-1:0] w;
      int k;
      w = '0;
      for (int i = 0; i < NUM_DISP; i++) begin
         k = int'(start) + i;
         if (k >= MSG_LEN) k = k - MSG_LEN;
         w[3*i +: 3] = msg[3*k +: 3];
      end
      return w;
   endfunction

   assign auto_req = bus.run && (div_cnt == DIV_LAST);
   assign step_req = !bus.run && bus.step && !step_q;

   always_comb begin
      next_off = off_q;
      if (bus.dir) begin
         next_off = (off_q == '0) ? OFF_LAST : off_q - 1'b1;
      end else begin
         next_off = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         msg_buf <= DEFAULT_MSG;
         off_q   <= '0;
         div_cnt <= '0;
         step_q  <= 1'b0;
         tick_q  <= 1'b0;
         codes_q <= window(DEFAULT_MSG, '0);
      end else begin
         step_q  <= bus.step;
         codes_q <= window(msg_buf, off_q);
         tick_q  <= 1'b0;

         if (!bus.run || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         // a load swallows any advance requested in the same cycle
         if (bus.msg_load) begin
            msg_buf <= bus.msg_data;
            off_q   <= '0;
            div_cnt <= '0;
         end else if (auto_req || step_req) begin
            off_q  <= next_off;
            tick_q <= 1'b1;
         end
      end
   end

   assign bus.codes  = codes_q;
   assign bus.offset = off_q;
   assign bus.tick   = tick_q;
endmodule

// File: tb/tb_char_rotator.sv
// tb/tb_char_rotator.sv - scoreboard bench for char_rotator with TICK_DIV=4 and message 0..7.
module tb_char_rotator;
   typedef struct {
      logic [2:0]  off;
      logic [17:0] codes;
   } exp_t;

   // window at each offset for message slots 0..7 = 0..7, digit 0 in the low octal digit
   localparam logic [17:0] EXP_CODES [8] = '{
      18'o543210, 18'o654321, 18'o765432, 18'o076543,
      18'o107654, 18'o210765, 18'o321076, 18'o432107
   };

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   bit   codes_pending = 0;
   logic [17:0] pend_codes;

   char_rotator_if #(.NUM_DISP(6), .MSG_LEN(8)) bus ();

   char_rotator #(
      .NUM_DISP(6), .MSG_LEN(8), .TICK_DIV(4), .DEFAULT_MSG(24'o76543210)
   ) dut (
      .CLOCK_50(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] off);
      exp_t e;
      e.off = off;
      e.codes = EXP_CODES[off];
      q.push_back(e);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((q.size() != 0 || codes_pending) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, q.size() + int'(codes_pending), 0);
   endtask

   always @(negedge clk) begin
      if (codes_pending) begin
         check("tick_codes", bus.codes, pend_codes);
         codes_pending = 0;
      end
      if (bus.tick === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_tick", bus.offset, 32'hffff_ffff);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("tick_offset", bus.offset, e.off);
            pend_codes = e.codes;
            codes_pending = 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1;
      bus.run = 1'b0;
      bus.dir = 1'b0;
      bus.step = 1'b0;
      bus.msg_load = 1'b0;
      bus.msg_data = '0;
      repeat (2) @(negedge clk);
      check("rst_offset", bus.offset, 0);
      check("rst_codes", bus.codes, 18'o543210);
      check("rst_tick", bus.tick, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rel_offset", bus.offset, 0);
      check("rel_codes", bus.codes, 18'o543210);
      check("rel_tick", bus.tick, 0);

      // auto scroll left through the wrap 7 -> 0
      for (int i = 1; i <= 8; i++) push(3'(i % 8));
      bus.run = 1'b1;
      drain("auto_left");
      bus.run = 1'b0;

      // scroll right from 0 wraps to 7
      bus.dir = 1'b1;
      push(3'd7);
      bus.run = 1'b1;
      drain("auto_right");
      bus.run = 1'b0;

      // held step gives one advance only
      push(3'd6);
      bus.step = 1'b1;
      repeat (10) @(negedge clk);
      bus.step = 1'b0;
      repeat (4) @(negedge clk);
      drain("manual_step");

      // step toggling while running adds nothing beyond the divider tick
      push(3'd5);
      bus.run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.step = ~bus.step;
      end
      bus.run = 1'b0;
      repeat (4) @(negedge clk);
      drain("step_while_run");
      check("pre_reset_offset", bus.offset, 5);

      // async reset between edges while scrolling
      bus.dir = 1'b0;
      bus.run = 1'b1;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_offset", bus.offset, 0);
      check("async_codes", bus.codes, 18'o543210);
      check("async_tick", bus.tick, 0);
      @(negedge clk);
      reset = 1'b0;
      bus.run = 1'b0;
      @(negedge clk);

      // load lands on the divider wrap cycle
      bus.run = 1'b1;
      repeat (3) @(negedge clk);
      bus.msg_load = 1'b1;
      bus.msg_data = {8{3'b101}};
      @(negedge clk);
      bus.msg_load = 1'b0;
      check("load_offset", bus.offset, 0);
      check("load_tick", bus.tick, 0);
      begin
         exp_t e;
         e.off = 3'd1;
         e.codes = 18'o555555;
         q.push_back(e);
      end
      @(negedge clk);
      check("load_codes", bus.codes, 18'o555555);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.tick !== 1'b1 && n < 20);
      check("load_period", n, 3);
      drain("after_load");
      bus.run = 1'b0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
